// File: rtl/wb_seq_pkg.sv
// wb_seq_pkg: constants and types shared by the writeback sequencer files.
//   - wb_src_t   : writeback source select codes (also used on S_MXRB)
//   - wb_state_t : sequencer FSM state encoding
//   - CNT_W/RD_W : memory wait counter width and register index width
package wb_seq_pkg;

    localparam int CNT_W = 4;
    localparam int RD_W  = 5;

    typedef enum logic [1:0] {
        SRC_PC  = 2'b00,   // link value (PC)
        SRC_DM  = 2'b01,   // load data from data memory
        SRC_ALU = 2'b10,   // ALU result
        SRC_ILL = 2'b11    // illegal encoding, never written
    } wb_src_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEM_WAIT = 2'b01,
        WRITE    = 2'b10
    } wb_state_t;

    // A load must wait for data memory; every other legal source writes at once.
    function automatic logic src_needs_mem(input logic [1:0] src);
        return src == SRC_DM;
    endfunction

endpackage

// File: rtl/wb_timer.sv
// wb_timer: clearable 4-bit wait counter for the data-memory wait.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one more waited cycle
//   expire     : high in the cycle whose increment makes the count reach
//                TIMEOUT, i.e. the TIMEOUT-th waited cycle
module wb_timer
    import wb_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = inc && (count_q == LAST);

endmodule

// File: rtl/wb_seq.sv
// wb_seq: register-bank writeback sequencer.
//   Accepts one writeback request at a time, waits for data memory on loads
//   (bounded by TIMEOUT), then issues a single write cycle to the register bank.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake; req_src/req_rd carried with it
//   dm_ready            : load data valid (only looked at while waiting)
//   flush               : abort whatever is in flight
//   S_MXRB, rb_waddr    : writeback mux select and address (hold between writes)
//   W_RB, wb_done       : write enable / completion pulse during the write cycle
//   err                 : one-cycle pulse for illegal source or memory timeout
//   dbg_state           : current FSM state for observation
//
// Handshake: a request transfers in any cycle where req_valid && req_ready and
// flush is low; req_ready is high exactly when the sequencer is IDLE and does
// not depend on req_valid. The requester holds req_src/req_rd with req_valid.
module wb_seq
    import wb_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [1:0]      req_src,
    input  logic [RD_W-1:0] req_rd,
    output logic            req_ready,
    input  logic            dm_ready,
    input  logic            flush,
    output logic [1:0]      S_MXRB,
    output logic            W_RB,
    output logic [RD_W-1:0] rb_waddr,
    output logic            wb_done,
    output logic            err,
    output wb_state_t       dbg_state
);

    wb_state_t       state_q, state_d;
    logic [1:0]      src_q, src_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            err_q, err_d;

    logic tmr_clr;
    logic tmr_inc;
    logic tmr_expire;

    // The counter is held at zero outside MEM_WAIT, so it always starts from
    // zero on entry without needing a separate entry strobe.
    assign tmr_clr = flush || (state_q != MEM_WAIT);
    assign tmr_inc = (state_q == MEM_WAIT) && !dm_ready;

    wb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        rd_d    = rd_q;
        err_d   = 1'b0;

        if (flush) begin
            // Flush beats everything: no accept, no error, no write next cycle.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        src_d = req_src;
                        rd_d  = req_rd;
                        if (src_needs_mem(req_src)) begin
                            state_d = MEM_WAIT;
                        end else if (wb_src_t'(req_src) == SRC_ILL) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Data arriving in the timeout cycle still completes the load.
                    if (dm_ready) begin
                        state_d = WRITE;
                    end else if (tmr_expire) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                WRITE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= SRC_PC;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Select and address come straight from the latched request so they hold
    // their last values while idle; in MEM_WAIT the latched source is SRC_DM.
    assign req_ready = (state_q == IDLE);
    assign S_MXRB    = src_q;
    assign rb_waddr  = rd_q;
    assign wb_done   = (state_q == WRITE) && !flush;
    assign W_RB      = wb_done && (rd_q != '0);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_seq.sv
module tb_wb_seq;
    import wb_seq_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1 << 30;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0;
    logic [1:0]      req_src   = 2'b00;
    logic [RD_W-1:0] req_rd    = '0;
    logic            dm_ready  = 1'b0;
    logic            flush     = 1'b0;
    logic            req_ready;
    logic [1:0]      S_MXRB;
    logic            W_RB;
    logic [RD_W-1:0] rb_waddr;
    logic            wb_done;
    logic            err;
    wb_state_t       dbg_state;

    wb_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_rd    (req_rd),
        .req_ready (req_ready),
        .dm_ready  (dm_ready),
        .flush     (flush),
        .S_MXRB    (S_MXRB),
        .W_RB      (W_RB),
        .rb_waddr  (rb_waddr),
        .wb_done   (wb_done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    // Event-time model: each accepted request schedules the cycle of its
    // write or error and the first cycle a new request may be taken.
    logic [1:0]      m_src;
    logic [RD_W-1:0] m_rd;
    int              m_write_at;
    int              m_err_at;
    int              m_free_at;
    bit              m_waiting;
    int              m_waited;

    task automatic model_reset();
        m_src      = 2'b00;
        m_rd       = '0;
        m_write_at = -1;
        m_err_at   = -1;
        m_free_at  = 0;
        m_waiting  = 1'b0;
        m_waited   = 0;
    endtask

    // Called at the rising edge that ends cycle 'cyc', with that cycle's inputs.
    task automatic model_step();
        if (flush) begin
            m_write_at = -1;
            m_waiting  = 1'b0;
            m_free_at  = cyc + 1;
        end else if (m_waiting) begin
            if (dm_ready) begin
                m_write_at = cyc + 1;
                m_free_at  = cyc + 2;
                m_waiting  = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_err_at  = cyc + 1;
                    m_free_at = cyc + 1;
                    m_waiting = 1'b0;
                end
            end
        end else if (req_valid && cyc >= m_free_at) begin
            m_src = req_src;
            m_rd  = req_rd;
            case (req_src)
                2'b01: begin
                    m_waiting = 1'b1;
                    m_waited  = 0;
                    m_free_at = NEVER;
                end
                2'b11: begin
                    m_err_at  = cyc + 1;
                    m_free_at = cyc + 1;
                end
                default: begin
                    m_write_at = cyc + 1;
                    m_free_at  = cyc + 2;
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic exp_done;
        exp_done = (cyc == m_write_at) && !flush;
        check("req_ready", 8'(cyc >= m_free_at), 8'(req_ready));
        total--; // re-issued below in observed/expected order
        check("req_ready", 8'(req_ready), 8'(cyc >= m_free_at));
        check("s_mxrb",    8'(S_MXRB),    8'(m_src));
        check("rb_waddr",  8'(rb_waddr),  8'(m_rd));
        check("wb_done",   8'(wb_done),   8'(exp_done));
        check("w_rb",      8'(W_RB),      8'(exp_done && (m_rd != '0)));
        check("err",       8'(err),       8'(cyc == m_err_at));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [1:0] src, input logic [RD_W-1:0] rd,
                         input logic dm, input logic fl);
        req_valid = v;
        req_src   = src;
        req_rd    = rd;
        dm_ready  = dm;
        flush     = fl;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Asserts reset in the middle of the current cycle, checks the
    // asynchronous clear before any clock edge, then releases it.
    task automatic apply_reset();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_s_mxrb",    8'(S_MXRB),    8'h00);
        check("rst_rb_waddr",  8'(rb_waddr),  8'h00);
        check("rst_w_rb",      8'(W_RB),      8'h00);
        check("rst_wb_done",   8'(wb_done),   8'h00);
        check("rst_err",       8'(err),       8'h00);
        check("rst_req_ready", 8'(req_ready), 8'h01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc++;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        apply_reset();
        run_n(2);

        // ALU rd=5: write the next cycle, ready again the cycle after
        drive(1'b1, SRC_ALU, 5'd5, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);

        // PC then ALU held valid: second is only taken after the write cycle
        drive(1'b1, SRC_PC, 5'd3, 1'b0, 1'b0);  run_cycle();
        drive(1'b1, SRC_ALU, 5'd9, 1'b0, 1'b0); run_n(2);
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);

        // Load rd=7, data ready 3 cycles after accept
        drive(1'b1, SRC_DM, 5'd7, 1'b0, 1'b0);  run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);
        dm_ready = 1'b1;                          run_cycle();
        dm_ready = 1'b0;                          run_n(2);

        // Load that never gets data: timeout error
        drive(1'b1, SRC_DM, 5'd12, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(TIMEOUT + 2);

        // Data arrives in the timeout cycle: write, no error
        drive(1'b1, SRC_DM, 5'd13, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(TIMEOUT - 1);
        dm_ready = 1'b1;                          run_cycle();
        dm_ready = 1'b0;                          run_n(2);

        // Illegal source: error pulse, no write
        drive(1'b1, SRC_ILL, 5'd4, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);

        // PC to rd=0: done pulses but no write enable
        drive(1'b1, SRC_PC, 5'd0, 1'b0, 1'b0);  run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);

        // dm_ready while idle is ignored
        drive(1'b0, SRC_PC, 5'd0, 1'b1, 1'b0);  run_n(2);

        // Flush during memory wait (data shows up with the flush)
        drive(1'b1, SRC_DM, 5'd9, 1'b0, 1'b0);  run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);
        drive(1'b0, SRC_PC, 5'd0, 1'b1, 1'b1);  run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b1, 1'b0);  run_n(3);

        // Flush during the write cycle suppresses the write
        drive(1'b1, SRC_ALU, 5'd6, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b1);  run_cycle();
        flush = 1'b0;                             run_cycle();

        // Flush overrides accept, including an illegal request
        drive(1'b1, SRC_ALU, 5'd8, 1'b0, 1'b1); run_cycle();
        drive(1'b1, SRC_ILL, 5'd2, 1'b0, 1'b1); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_n(2);

        // Reset during the write cycle
        drive(1'b1, SRC_ALU, 5'd11, 1'b0, 1'b0); run_cycle();
        apply_reset();
        run_n(2);

        // Reset during memory wait; late data must not cause a write
        drive(1'b1, SRC_DM, 5'd21, 1'b0, 1'b0); run_cycle();
        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);  run_cycle();
        apply_reset();
        dm_ready = 1'b1;                          run_n(2);
        dm_ready = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'b0, 1'b0);
            req_valid = ($urandom_range(0, 99) < 60);
            dm_ready  = ($urandom_range(0, 99) < 15);
            flush     = ($urandom_range(0, 99) < 4);
            run_cycle();
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        drive(1'b0, SRC_PC, 5'd0, 1'b0, 1'b0);
        run_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
